// File: rtl/qif_sweep_scheduler_pkg.sv
// qif_pkg: shared constants, FSM state type and the QIF arithmetic used by
// qif_sweep_scheduler.
//   V_RESET_DEF / V_PEAK_DEF : default post-spike value and spike threshold
//   state_t                  : sweep FSM states
//   sat8()                   : clamp a 16-bit signed sum to [-128, 127]
//   qif_step()               : one QIF membrane update, no spike test
package qif_pkg;

    localparam logic signed [7:0] V_RESET_DEF = -8'sd20;
    localparam logic signed [7:0] V_PEAK_DEF  = 8'sd50;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic signed [7:0] sat8(input logic signed [15:0] x);
        if (x > 16'sd127)
            return 8'sh7f;
        else if (x < -16'sd128)
            return 8'sh80;
        else
            return x[7:0];
    endfunction

    // V + (B >>> 2) + (V*V >> 4), summed in 16-bit signed.
    // V*V is formed from |V| so the square stays an unsigned 15-bit value
    // (128*128 = 16384 is the largest case).
    function automatic logic signed [7:0] qif_step(input logic signed [7:0] v,
                                                   input logic signed [7:0] b);
        logic [7:0]         mag;
        logic [14:0]        sq;
        logic signed [15:0] v16;
        logic signed [15:0] b16;
        logic signed [15:0] sum;
        mag = v[7] ? 8'(-v) : v;
        sq  = 15'(mag) * 15'(mag);
        v16 = {{8{v[7]}}, v};
        b16 = {{8{b[7]}}, b};
        sum = v16 + (b16 >>> 2) + $signed({5'b0, sq[14:4]});
        return sat8(sum);
    endfunction

endpackage

// File: rtl/qif_sweep_scheduler_if.sv
// Configuration and spike-event bus of qif_sweep_scheduler.
//   cfg_we/cfg_addr/cfg_data : write strobe, neuron index, signed B value
//   evt_valid/evt_ready      : spike-event handshake toward the spike router
//   evt_id                   : index of the spiking neuron at the FIFO head
// master = scheduler side, slave = configuring / event-consuming side.
interface qif_sweep_scheduler_if #(
    parameter int IDX_W = 3
) ();
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [7:0]       cfg_data;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_id;

    modport master (
        input  cfg_we, cfg_addr, cfg_data, evt_ready,
        output evt_valid, evt_id
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_data, evt_ready,
        input  evt_valid, evt_id
    );
endinterface

// File: rtl/qif_sweep_scheduler_fifo.sv
// spike_event_fifo: small circular FIFO of spike ids.
//   clk, rst_n      : clock, asynchronous active-high reset
//   push, push_data : write request; accepted when not full, or when full and
//                     a pop happens in the same cycle
//   full            : FIFO holds DEPTH entries
//   pop             : read request, only acts while valid
//   valid, head     : non-empty flag and head entry (head reads 0 when empty)
// Dropped pushes are counted by the parent.
module spike_event_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    do_push;
    logic                    do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/qif_sweep_scheduler.sv
// qif_sweep_scheduler: one QIF update datapath shared by NUM_NEURONS virtual
// neurons. Each tick sweeps all neurons once in index order, one per cycle.
//   clk, rst_n       : clock; rst_n is an asynchronous reset asserted HIGH
//   tick             : starts a sweep; a tick while busy only sets overrun
//   busy             : sweep in progress
//   sweep_done       : one-cycle pulse after the last neuron update
//   overrun          : sticky, cleared only by reset
//   obs_addr, obs_v  : registered V observation port (out of range -> 0)
//   drop_cnt         : saturating count of spikes lost to a full FIFO
//   bus (master)     : B configuration writes and spike-event stream
module qif_sweep_scheduler
    import qif_pkg::*;
#(
    parameter int               NUM_NEURONS = 8,
    parameter int               IDX_W       = 3,
    parameter int               FIFO_DEPTH  = 4,
    parameter logic signed [7:0] V_RESET    = V_RESET_DEF,
    parameter logic signed [7:0] V_PEAK     = V_PEAK_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    overrun,
    input  logic [IDX_W-1:0]        obs_addr,
    output logic [7:0]              obs_v,
    output logic [7:0]              drop_cnt,
    qif_sweep_scheduler_if.master   bus
);
    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_NEURONS-1:0][7:0]    v_q;
    logic [NUM_NEURONS-1:0][7:0]    b_q;

    logic                           upd;
    logic                           last;
    logic                           spike;
    logic signed [7:0]              v_cur;
    logic signed [7:0]              b_cur;
    logic signed [7:0]              v_next;
    logic                           fifo_full;
    logic                           drop;
    logic                           cfg_ok;
    logic                           obs_ok;

    assign last   = (idx_q == IDX_W'(NUM_NEURONS - 1));
    assign busy   = (state_q == RUN);
    assign cfg_ok = bus.cfg_we && ({1'b0, bus.cfg_addr} < (IDX_W+1)'(NUM_NEURONS));
    assign obs_ok = ({1'b0, obs_addr} < (IDX_W+1)'(NUM_NEURONS));

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        upd     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                upd = 1'b1;
                if (last)
                    state_d = IDLE;
                else
                    idx_d = idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    // The spike test looks at the stored V, so a neuron that crosses V_PEAK
    // fires on the following sweep.
    assign v_cur  = $signed(v_q[idx_q]);
    assign b_cur  = $signed(b_q[idx_q]);
    assign spike  = upd && (v_cur >= V_PEAK);
    assign v_next = spike ? V_RESET : qif_step(v_cur, b_cur);

    // A cfg write to the neuron being updated lands in b_q at the same edge,
    // so the update naturally consumes the old B.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            v_q <= {NUM_NEURONS{V_RESET}};
            b_q <= '0;
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (upd && idx_q == IDX_W'(i))
                    v_q[i] <= v_next;
            end
            if (cfg_ok)
                b_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // ---------------- status / observation ----------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sweep_done <= 1'b0;
            overrun    <= 1'b0;
            obs_v      <= '0;
            drop_cnt   <= '0;
        end else begin
            sweep_done <= upd && last;
            if (tick && busy)
                overrun <= 1'b1;
            obs_v <= obs_ok ? v_q[obs_addr] : '0;
            if (drop && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // ---------------- spike event queue ----------------
    assign drop = spike && fifo_full && !(bus.evt_valid && bus.evt_ready);

    spike_event_fifo #(
        .W     (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (spike),
        .push_data (idx_q),
        .full      (fifo_full),
        .pop       (bus.evt_ready),
        .valid     (bus.evt_valid),
        .head      (bus.evt_id)
    );
endmodule
